// File: rtl/neuron_decay_pkg.sv
// Shared types and constants for the neuron decay sweep scheduler.
package neuron_decay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_DECAY,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [3:0] DECAY_DIV1        = 4'b0001;
  localparam logic [3:0] DECAY_DIV2        = 4'b0010;
  localparam logic [3:0] DECAY_DIV4        = 4'b0100;
  localparam logic [3:0] DECAY_DIV8        = 4'b1000;
  localparam logic [3:0] DECAY_DIV2_PLUS_4 = 4'b0011;

  localparam logic [1:0] MODEL_LIF  = 2'b00;
  localparam logic [1:0] MODEL_IZHI = 2'b01;
  localparam logic [1:0] MODEL_QLIF = 2'b10;

  localparam logic [3:0] RATE_RST  = DECAY_DIV2;
  localparam logic [1:0] MODEL_RST = MODEL_LIF;

  typedef struct packed {
    logic [3:0] rate;
    logic [1:0] model;
  } cfg_entry_t;

  localparam cfg_entry_t CFG_RST = '{rate: RATE_RST, model: MODEL_RST};

  // Table index width; at least one bit so a single-neuron cluster still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decay_config_table.sv
// Per-neuron decay configuration register file: one write port, one asynchronous read port.
module decay_config_table
  import neuron_decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 20,
  parameter int unsigned IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  cfg_entry_t       i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output cfg_entry_t       o_rd_data
);

  cfg_entry_t r_tbl [NUM_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        r_tbl[i] <= CFG_RST;
      end
    end else if (i_we) begin
      r_tbl[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_tbl[i_rd_addr];

endmodule

// File: rtl/neuron_decay_scheduler.sv
// Per-timestep decay sweep: read each potential, hand it to the shared decay unit, write it back.
module neuron_decay_scheduler
  import neuron_decay_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 20,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timestep,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_decay_rate,
  input  logic [1:0]        cfg_model,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              dec_req,
  output logic [DATA_W-1:0] dec_potential,
  output logic [3:0]        dec_rate,
  output logic [1:0]        dec_model,
  input  logic              dec_ack,
  input  logic [DATA_W-1:0] dec_result,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              cfg_reject
);

  localparam int unsigned       IDX_W    = idx_width(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NUM_NEURONS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;

  logic       w_cfg_addr_ok;
  logic       w_cfg_accept;
  cfg_entry_t w_cfg_wr;
  cfg_entry_t w_cfg_rd;

  assign w_cfg_addr_ok = ({1'b0, cfg_addr} < NUM_EXT);
  assign w_cfg_accept  = cfg_we && (r_state == ST_IDLE) && w_cfg_addr_ok;
  assign w_cfg_wr      = '{rate: cfg_decay_rate, model: cfg_model};

  decay_config_table #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_cfg_accept),
    .i_wr_addr (cfg_addr[IDX_W-1:0]),
    .i_wr_data (w_cfg_wr),
    .i_rd_addr (r_idx[IDX_W-1:0]),
    .o_rd_data (w_cfg_rd)
  );

  // Outputs are loaded on the transition into the state that owns them, so each
  // strobe is visible exactly during that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      dec_req       <= 1'b0;
      dec_potential <= '0;
      dec_rate      <= '0;
      dec_model     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      cfg_reject    <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      done       <= 1'b0;
      overrun    <= timestep && (r_state != ST_IDLE);
      cfg_reject <= cfg_we && ((r_state != ST_IDLE) || !w_cfg_addr_ok);

      unique case (r_state)
        ST_IDLE: begin
          if (timestep) begin
            r_state     <= ST_READ;
            r_idx       <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
            busy        <= 1'b1;
          end
        end
        ST_READ: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          dec_potential <= mem_rd_data;
          dec_rate      <= w_cfg_rd.rate;
          dec_model     <= w_cfg_rd.model;
          dec_req       <= 1'b1;
          r_state       <= ST_DECAY;
        end
        ST_DECAY: begin
          if (dec_ack) begin
            dec_req     <= 1'b0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= r_idx;
            mem_wr_data <= dec_result;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_idx == LAST_IDX) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx       <= r_idx + 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= r_idx + 1'b1;
            r_state     <= ST_READ;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/neuron_decay_scheduler.md
# neuron_decay_scheduler

Sequences the per-timestep membrane-potential decay sweep for a neuron cluster. On each timestep tick it walks every neuron address, reads the stored potential from the potential memory, and hands it to the shared decay unit with that neuron's configured decay rate and model. It then writes the decayed result back and pulses `done` when the whole cluster has been processed. It sits between the timestep generator, the potential memory and the single decay datapath, and owns the per-neuron decay configuration table.

## Interface
Parameters:
- `NUM_NEURONS`, default 20: neurons in the cluster; legal range 1..4096.
- `ADDR_W`, default 12: neuron address width.
- `DATA_W`, default 32: potential width, IEEE-754 single.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `timestep` input 1: one-cycle tick that starts a sweep.
- `cfg_we` input 1: configuration write strobe.
- `cfg_addr` input ADDR_W: neuron whose configuration is written.
- `cfg_decay_rate` input 4: decay code.
- `cfg_model` input 2: model code, where 00 = LIF.
- `mem_rd_en` output 1: potential memory read strobe.
- `mem_rd_addr` output ADDR_W: read address.
- `mem_rd_data` input DATA_W: read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en` output 1: write-back strobe.
- `mem_wr_addr` output ADDR_W: write-back address.
- `mem_wr_data` output DATA_W: write-back data.
- `dec_req` output 1: decay request.
- `dec_potential` output DATA_W: potential presented to the decay unit.
- `dec_rate` output 4: decay code presented to the decay unit.
- `dec_model` output 2: model code presented to the decay unit.
- `dec_ack` input 1: decay result valid; completes the request.
- `dec_result` input DATA_W: decayed potential.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle pulse at sweep end.
- `overrun` output 1: one-cycle pulse when a `timestep` arrives while busy.
- `cfg_reject` output 1: one-cycle pulse when `cfg_we` arrives while busy, or when `cfg_addr >= NUM_NEURONS`.

## Operation
- States: IDLE, READ, LATCH, DECAY, WRITE, DONE.
- IDLE:
  - `timestep` → READ, with the neuron index cleared to 0.
  - `cfg_we` with a valid address writes the table entry.
- READ: `mem_rd_en`=1 and `mem_rd_addr`=index → LATCH.
- LATCH: capture `mem_rd_data`, plus the table rate and model for the index → DECAY.
- DECAY:
  - `dec_req`=1, with `dec_potential`, `dec_rate` and `dec_model` held stable until `dec_ack`.
  - `dec_ack` may arrive in the first DECAY cycle.
  - On `dec_ack`, capture `dec_result` → WRITE.
  - `dec_ack` outside DECAY is ignored.
- WRITE:
  - `mem_wr_en`=1 with `mem_wr_addr`=index and `mem_wr_data`=captured result.
  - If index = `NUM_NEURONS`-1 → DONE; otherwise increment index → READ.
- DONE: `done`=1 → IDLE.
- Decay codes are forwarded unchanged. Legal codes are 0001, 0010, 0100, 1000 and 0011; the decay unit treats any other code as divide-by-1.
- The index counter never wraps within a sweep. A sweep is never restarted mid-flight; `timestep` while busy is dropped and pulses `overrun`.
- `timestep` in the DONE cycle counts as busy: it is dropped and pulses `overrun`.
- Configuration reset value for every entry: rate 0010 (divide by 2), model 00.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State IDLE, index 0.
  - All outputs 0, including `mem_*_addr`, `mem_*_data` and `dec_*` buses.
  - Configuration table returns to defaults.
- Reset mid-sweep aborts immediately. No `done` is produced. Already-written neurons keep their decayed value; the rest are untouched.
- Per-neuron cost is 4 + (cycles waiting for `dec_ack` beyond the first DECAY cycle).
- With zero-wait ack and `timestep` sampled in cycle 0:
  - READ for neuron k occurs in cycle 4k+1; WRITE in cycle 4k+4.
  - `done` occurs in cycle 4·NUM_NEURONS+1.
  - `busy` is high in cycles 1..4·NUM_NEURONS+1.
- `done`, `overrun`, `cfg_reject`, `mem_rd_en`, `mem_wr_en` and `dec_req` are registered outputs.
- Simultaneous `timestep` and `cfg_we` in IDLE: the config write is accepted and the sweep starts. The new value applies because LATCH reads the table at least 2 cycles later.

## Structure
- Package `neuron_decay_pkg`:
  - State enum.
  - Decay codes `DECAY_DIV1`, `DECAY_DIV2`, `DECAY_DIV4`, `DECAY_DIV8`, `DECAY_DIV2_PLUS_4`.
  - Model codes `MODEL_LIF`, `MODEL_IZHI`, `MODEL_QLIF`.
  - Reset defaults `RATE_RST`=0010 and `MODEL_RST`=00.
- Sub-module `decay_config_table`:
  - NUM_NEURONS×6-bit register file.
  - One write port and one asynchronous read port.
  - Asynchronous reset to defaults.

## Test plan
- Reset then `timestep`, NUM_NEURONS=20, memory preloaded with 0x41DED852 everywhere, zero-wait ack model halving the exponent:
  - Every address is rewritten to 0x415ED852.
  - `done` occurs in cycle 81; `busy` is high in cycles 1..81.
- Config neuron 3 with rate 0011 and model 00, then sweep: `dec_rate`=0011 only while index=3; all other neurons show 0010.
- Ack stall: `dec_ack` delayed 5 cycles on neuron 7. `dec_*` buses stay stable for all stalled cycles; `done` shifts by exactly 5 cycles.
- `timestep` pulsed during the sweep and again in the DONE cycle: `overrun` pulses twice; exactly one `done`; no second sweep.
- `cfg_we` while busy, and `cfg_addr`=20 while idle: `cfg_reject` pulses on both; table entries are unchanged.
- Assert `rst_n` low after neuron 9's WRITE:
  - All outputs are 0 immediately.
  - Addresses 0..9 are decayed and 10..19 are unchanged.
  - No `done`; config is back to defaults.
